// File: rtl/seven_seg_status_scroller.sv
// seven_seg_status_scroller
//
// Status-message driver for a bank of NUM_DIGITS active-low seven-segment
// digits. The recorder state code (and, while playing, the speed code) picks
// a short text message. Messages that fit are shown right-aligned. Longer
// messages scroll right-to-left, with one blank appended before the text
// repeats. The PAUSE message blinks. Scroll and blink advance once every
// STEP_CYCLES clocks.
//
// Parameters
//   NUM_DIGITS   number of digits driven (4..8)
//   STEP_CYCLES  clocks per scroll/blink step (>= 2)
//
// Ports
//   i_clk    system clock, rising edge
//   i_rst    synchronous active-high reset
//   i_state  recorder state: 0 INIT, 1 IDLE, 2 RECORD, 3 STOP, 4 PLAY,
//            5 PAUSE; 6 and 7 are invalid and light every segment
//   i_speed  bit 4 = slower (minus sign), bits 3:0 = speed factor
//   o_seven  digit k at [7k+6:7k], digit 0 rightmost, segment i at bit i,
//            active-low; driven only from registers
//   o_step   one-cycle pulse in the last cycle of each step period
module seven_seg_status_scroller #(
  parameter int NUM_DIGITS  = 6,
  parameter int STEP_CYCLES = 25_000_000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [2:0]              i_state,
  input  logic [4:0]              i_speed,
  output logic [7*NUM_DIGITS-1:0] o_seven,
  output logic                    o_step
);

  localparam int             PW   = $clog2(STEP_CYCLES);
  localparam logic [PW-1:0]  TERM = PW'(STEP_CYCLES - 1);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_RECORD = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_PLAY   = 3'd4;
  localparam logic [2:0] S_PAUSE  = 3'd5;

  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [6:0] G_MINUS = 7'b0111111;
  localparam logic [6:0] G_A     = 7'b0001000;
  localparam logic [6:0] G_C     = 7'b1000110;
  localparam logic [6:0] G_D     = 7'b1000000;
  localparam logic [6:0] G_E     = 7'b0000110;
  localparam logic [6:0] G_I     = 7'b1111001;
  localparam logic [6:0] G_L     = 7'b1000111;
  localparam logic [6:0] G_N     = 7'b1001000;
  localparam logic [6:0] G_O     = 7'b1000000;
  localparam logic [6:0] G_P     = 7'b0001100;
  localparam logic [6:0] G_R     = 7'b0001000;
  localparam logic [6:0] G_S     = 7'b0010010;
  localparam logic [6:0] G_T     = 7'b1001110;
  localparam logic [6:0] G_U     = 7'b1000001;
  localparam logic [6:0] G_Y     = 7'b0010001;
  localparam logic [6:0] G_2     = 7'b0100100;
  localparam logic [6:0] G_3     = 7'b0110000;
  localparam logic [6:0] G_4     = 7'b0011001;
  localparam logic [6:0] G_5     = 7'b0010010;
  localparam logic [6:0] G_6     = 7'b0000010;
  localparam logic [6:0] G_7     = 7'b1011000;
  localparam logic [6:0] G_8     = 7'b0000000;

  // Message length per state; invalid states report 0 so they never scroll.
  function automatic logic [2:0] msg_len(input logic [2:0] st);
    logic [2:0] len;
    case (st)
      S_INIT, S_IDLE, S_STOP: len = 3'd4;
      S_RECORD, S_PLAY:       len = 3'd6;
      S_PAUSE:                len = 3'd5;
      default:                len = 3'd0;
    endcase
    return len;
  endfunction

  // Only speed factors 2..8 have a digit; anything else leaves the slot blank.
  function automatic logic [6:0] speed_glyph(input logic [3:0] f);
    logic [6:0] g;
    case (f)
      4'd2:    g = G_2;
      4'd3:    g = G_3;
      4'd4:    g = G_4;
      4'd5:    g = G_5;
      4'd6:    g = G_6;
      4'd7:    g = G_7;
      4'd8:    g = G_8;
      default: g = G_BLANK;
    endcase
    return g;
  endfunction

  // Glyph of character i (0 = leftmost) of the message for state st.
  function automatic logic [6:0] msg_char(input logic [2:0] st,
                                          input logic [4:0] spd,
                                          input logic [2:0] i);
    logic [6:0] g;
    g = G_BLANK;
    case (st)
      S_INIT: case (i)
        3'd0: g = G_I;  3'd1: g = G_N;  3'd2: g = G_I;  default: g = G_T;
      endcase
      S_IDLE: case (i)
        3'd0: g = G_I;  3'd1: g = G_D;  3'd2: g = G_L;  default: g = G_E;
      endcase
      S_STOP: case (i)
        3'd0: g = G_S;  3'd1: g = G_T;  3'd2: g = G_O;  default: g = G_P;
      endcase
      S_RECORD: case (i)
        3'd0: g = G_R;  3'd1: g = G_E;  3'd2: g = G_C;
        3'd3: g = G_O;  3'd4: g = G_R;  default: g = G_D;
      endcase
      S_PAUSE: case (i)
        3'd0: g = G_P;  3'd1: g = G_A;  3'd2: g = G_U;
        3'd3: g = G_S;  default: g = G_E;
      endcase
      S_PLAY: case (i)
        3'd0: g = spd[4] ? G_MINUS : G_BLANK;
        3'd1: g = speed_glyph(spd[3:0]);
        3'd2: g = G_P;  3'd3: g = G_L;  3'd4: g = G_A;  default: g = G_Y;
      endcase
      default: g = G_BLANK;
    endcase
    return g;
  endfunction

  logic [2:0]    r_state, state_n;
  logic [4:0]    r_speed;
  logic [2:0]    pos, pos_n;
  logic [PW-1:0] prescaler, prescaler_n;
  logic          blink_on, blink_n;
  logic          step;

  logic [2:0]    len_r;
  logic          invalid;
  logic          scroll;
  logic          term;
  logic          chg;

  assign len_r   = msg_len(r_state);
  assign invalid = (r_state > S_PAUSE);
  assign scroll  = ({1'b0, len_r} > 4'(NUM_DIGITS));
  assign term    = (prescaler == TERM);
  assign chg     = (i_state != r_state);

  // A state change restarts the step timer and swallows any coinciding step.
  always_comb begin
    state_n     = r_state;
    pos_n       = pos;
    blink_n     = blink_on;
    step        = 1'b0;
    prescaler_n = term ? '0 : prescaler + 1'b1;
    if (chg) begin
      state_n     = i_state;
      pos_n       = '0;
      prescaler_n = '0;
      blink_n     = 1'b1;
    end else if (term) begin
      step    = 1'b1;
      blink_n = ~blink_on;
      if (scroll) pos_n = (pos == len_r) ? 3'd0 : pos + 3'd1;
    end
  end

  assign o_step = step & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_INIT;
      r_speed   <= '0;
      pos       <= '0;
      prescaler <= '0;
      blink_on  <= 1'b1;
    end else begin
      r_state   <= state_n;
      r_speed   <= i_speed;
      pos       <= pos_n;
      prescaler <= prescaler_n;
      blink_on  <= blink_n;
    end
  end

  // Display decode. In scroll mode the virtual string is the message plus one
  // trailing blank (period L+1); idx never exceeds 2L+1 there because
  // NUM_DIGITS < L, so a single wrap subtraction is enough.
  logic [6:0] seg;
  logic [4:0] idx;
  logic [4:0] len5;

  always_comb begin
    o_seven = '1;
    seg     = G_BLANK;
    idx     = '0;
    len5    = {2'b00, len_r};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      seg = G_BLANK;
      idx = '0;
      if (invalid) begin
        seg = 7'b0000000;
      end else if (!scroll) begin
        if (5'(k) < len5) seg = msg_char(r_state, r_speed, 3'(len5 - 5'(k) - 5'd1));
      end else begin
        idx = {2'b00, pos} + 5'(NUM_DIGITS - 1 - k);
        if (idx > len5) idx = idx - len5 - 5'd1;
        if (idx != len5) seg = msg_char(r_state, r_speed, idx[2:0]);
      end
      if ((r_state == S_PAUSE) && !blink_on) seg = G_BLANK;
      o_seven[7*k +: 7] = seg;
    end
  end

endmodule

// File: tb/tb_seven_seg_status_scroller.sv
module tb_seven_seg_status_scroller;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;
  localparam logic [6:0] CA = 7'b0001000;
  localparam logic [6:0] CC = 7'b1000110;
  localparam logic [6:0] CD = 7'b1000000;
  localparam logic [6:0] CE = 7'b0000110;
  localparam logic [6:0] CI = 7'b1111001;
  localparam logic [6:0] CL = 7'b1000111;
  localparam logic [6:0] CN = 7'b1001000;
  localparam logic [6:0] CO = 7'b1000000;
  localparam logic [6:0] CP = 7'b0001100;
  localparam logic [6:0] CR = 7'b0001000;
  localparam logic [6:0] CS = 7'b0010010;
  localparam logic [6:0] CT = 7'b1001110;
  localparam logic [6:0] CU = 7'b1000001;
  localparam logic [6:0] CY = 7'b0010001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D8 = 7'b0000000;

  logic        clk;
  logic        rst;
  logic [2:0]  st6, st4;
  logic [4:0]  spd;
  logic [41:0] seven6;
  logic [27:0] seven4;
  logic        step6, step4;

  int passed = 0;
  int total  = 0;

  seven_seg_status_scroller #(.NUM_DIGITS(6), .STEP_CYCLES(4)) dut6 (
    .i_clk(clk), .i_rst(rst), .i_state(st6), .i_speed(spd),
    .o_seven(seven6), .o_step(step6));

  seven_seg_status_scroller #(.NUM_DIGITS(4), .STEP_CYCLES(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_state(st4), .i_speed(spd),
    .o_seven(seven4), .o_step(step4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [41:0] p6(input logic [6:0] d5, d4, d3, d2, d1, d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  function automatic logic [27:0] p4(input logic [6:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  logic [27:0] rec_scroll [0:6];
  logic [2:0]  step_exp;

  initial begin
    rec_scroll[0] = p4(CR, CE, CC, CO);
    rec_scroll[1] = p4(CE, CC, CO, CR);
    rec_scroll[2] = p4(CC, CO, CR, CD);
    rec_scroll[3] = p4(CO, CR, CD, BL);
    rec_scroll[4] = p4(CR, CD, BL, CR);
    rec_scroll[5] = p4(CD, BL, CR, CE);
    rec_scroll[6] = p4(BL, CR, CE, CC);

    rst = 1'b1; st6 = 3'd0; st4 = 3'd0; spd = 5'd0;
    tick();
    chk("rst_init6", 64'(seven6), 64'(p6(BL, BL, CI, CN, CI, CT)));
    chk("rst_init4", 64'(seven4), 64'(p4(CI, CN, CI, CT)));
    chk("rst_step", 64'(step6), 64'(1'b0));
    rst = 1'b0;

    // Pulses land on the 4th, 8th cycle after reset
    step_exp = 3'b100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_step_a", 64'(step6), 64'(step_exp[i]));
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_step_b", 64'(step6), 64'(i == 3));
    end

    // State change on the terminal-count cycle: step is dropped
    st4 = 3'd2;
    #1;
    chk("chg_on_term_step", 64'(step4), 64'(1'b0));
    tick();
    chk("rec_pos0", 64'(seven4), 64'(rec_scroll[0]));
    chk("rec_pre_restart", 64'(step4), 64'(1'b0));

    // Full scroll period: 7 steps returns to the start
    for (int s = 1; s <= 7; s++) begin
      repeat (4) tick();
      chk("rec_scroll", 64'(seven4), 64'(rec_scroll[s % 7]));
    end

    // Scroll to pos 3, wait mid-count, then switch to STOP
    repeat (12) tick();
    chk("rec_pos3", 64'(seven4), 64'(rec_scroll[3]));
    repeat (2) tick();
    st4 = 3'd3;
    tick();
    chk("stop_text", 64'(seven4), 64'(p4(CS, CT, CO, CP)));
    chk("stop_step0", 64'(step4), 64'(1'b0));
    tick();
    chk("stop_step1", 64'(step4), 64'(1'b0));
    tick();
    chk("stop_step2", 64'(step4), 64'(1'b0));
    tick();
    chk("stop_step3", 64'(step4), 64'(1'b1));
    tick();
    chk("stop_static", 64'(seven4), 64'(p4(CS, CT, CO, CP)));

    // Invalid state lights everything, no motion
    st4 = 3'd7;
    tick();
    chk("invalid4", 64'(seven4), 64'(28'h0));
    repeat (5) tick();
    chk("invalid4_hold", 64'(seven4), 64'(28'h0));

    // RECORD to pos 4, then reset together with a state change
    st4 = 3'd2;
    tick();
    repeat (16) tick();
    chk("rec_pos4", 64'(seven4), 64'(rec_scroll[4]));
    rst = 1'b1; st4 = 3'd3;
    tick();
    chk("rst_mid_scroll", 64'(seven4), 64'(p4(CI, CN, CI, CT)));
    chk("rst_mid_step", 64'(step4), 64'(1'b0));
    rst = 1'b0; st4 = 3'd0;
    tick();
    chk("rst_cnt_a", 64'(step4), 64'(1'b0));
    tick();
    chk("rst_cnt_b", 64'(step4), 64'(1'b0));
    tick();
    chk("rst_cnt_c", 64'(step4), 64'(1'b1));
    chk("rst_init_hold", 64'(seven4), 64'(p4(CI, CN, CI, CT)));

    // PLAY with speed variants (prescaler keeps counting across speed changes)
    st6 = 3'd4; spd = 5'b10011;
    tick();
    chk("play_m3", 64'(seven6), 64'(p6(MI, D3, CP, CL, CA, CY)));
    tick();
    tick();
    spd = 5'b00001;
    tick();
    chk("play_sp1", 64'(seven6), 64'(p6(BL, BL, CP, CL, CA, CY)));
    chk("play_pre_kept", 64'(step6), 64'(1'b1));
    spd = 5'b01000;
    tick();
    chk("play_sp8", 64'(seven6), 64'(p6(BL, D8, CP, CL, CA, CY)));
    spd = 5'b10010;
    tick();
    chk("play_m2", 64'(seven6), 64'(p6(MI, D2, CP, CL, CA, CY)));
    spd = 5'b01001;
    tick();
    chk("play_sp9", 64'(seven6), 64'(p6(BL, BL, CP, CL, CA, CY)));

    // PAUSE blink: 4 on, 4 off, on again
    st6 = 3'd5;
    tick();
    chk("pause_on0", 64'(seven6), 64'(p6(BL, CP, CA, CU, CS, CE)));
    repeat (3) tick();
    chk("pause_on3", 64'(seven6), 64'(p6(BL, CP, CA, CU, CS, CE)));
    tick();
    chk("pause_off0", 64'(seven6), 64'(p6(BL, BL, BL, BL, BL, BL)));
    repeat (3) tick();
    chk("pause_off3", 64'(seven6), 64'(p6(BL, BL, BL, BL, BL, BL)));
    tick();
    chk("pause_on_again", 64'(seven6), 64'(p6(BL, CP, CA, CU, CS, CE)));

    st6 = 3'd6;
    tick();
    chk("invalid6", 64'(seven6), 64'(42'h0));

    st6 = 3'd1;
    tick();
    chk("idle6", 64'(seven6), 64'(p6(BL, BL, CI, CD, CL, CE)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
